// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame-format defaults
// common to the transmitter and receiver.
package uart_pkg;

  localparam int DBIT_DEF     = 8;
  localparam int OS_TICKS_DEF = 16;
  localparam int SB_BITS_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    START   = 3'b001,
    DATA    = 3'b010,
    STOP    = 3'b011,
    CLEANUP = 3'b100
  } uart_state_t;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side transmit port: baud tick, start strobe and byte in, serial line
// and status out.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
) ();

  logic            bd;
  logic            tx_start;
  logic [DBIT-1:0] tx_byte;
  logic            tx_serial;
  logic            tx_busy;
  logic            tx_done;

  modport master (
    output bd,
    output tx_start,
    output tx_byte,
    input  tx_serial,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  bd,
    input  tx_start,
    input  tx_byte,
    output tx_serial,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: shifts a latched byte out LSB-first with start
// and stop bits, timed by an external oversampling baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int OS_TICKS = OS_TICKS_DEF,
  parameter int SB_BITS  = SB_BITS_DEF
) (
  input  logic     i_Clock,
  input  logic     i_reset,
  uart_tx_if.slave tx
);

  localparam int TW = cnt_width(OS_TICKS);
  localparam int BW = cnt_width((DBIT > SB_BITS) ? DBIT : SB_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(OS_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DBIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(SB_BITS - 1);

  uart_state_t     state_reg, state_next;
  logic [TW-1:0]   tick_reg, tick_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic [DBIT-1:0] shift_reg, shift_next;
  logic            serial_reg, serial_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      serial_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      serial_reg <= serial_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // bit_reg counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;

    case (state_reg)
      IDLE: begin
        if (tx.tx_start) begin
          shift_next = tx.tx_byte;
          tick_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end

      START: begin
        if (tx.bd) begin
          if (tick_reg == TICK_LAST) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = DATA;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (tx.bd) begin
          if (tick_reg == TICK_LAST) begin
            tick_next  = '0;
            shift_next = shift_reg >> 1;
            if (bit_reg == DATA_LAST) begin
              bit_next   = '0;
              state_next = STOP;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (tx.bd) begin
          if (tick_reg == TICK_LAST) begin
            tick_next = '0;
            if (bit_reg == STOP_LAST) begin
              bit_next   = '0;
              state_next = CLEANUP;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      CLEANUP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs follow the registered state one cycle later so line and busy stay aligned.
  always_comb begin
    serial_next = 1'b1;
    busy_next   = (state_reg != IDLE);
    done_next   = (state_reg == CLEANUP);
    case (state_reg)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_reg[0];
      default: serial_next = 1'b1;
    endcase
  end

  assign tx.tx_serial = serial_reg;
  assign tx.tx_busy   = busy_reg;
  assign tx.tx_done   = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one-stop-bit and two-stop-bit instances, with
// line history recorded each clock and frames decoded from it.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = 16384;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic ser_h  [2][N];
  logic done_h [2][N];
  logic busy_h [2][N];

  uart_tx_if #(.DBIT(8)) if1 ();
  uart_tx_if #(.DBIT(8)) if2 ();

  uart_tx #(.DBIT(8), .OS_TICKS(16), .SB_BITS(1)) dut1 (
    .i_Clock(clk), .i_reset(rst), .tx(if1)
  );
  uart_tx #(.DBIT(8), .OS_TICKS(16), .SB_BITS(2)) dut2 (
    .i_Clock(clk), .i_reset(rst), .tx(if2)
  );

  always #5 clk = ~clk;

  // Baud tick every 4 clocks, shared by both instances.
  initial begin
    int bc;
    bc = 0;
    if1.bd = 1'b0;
    if2.bd = 1'b0;
    forever begin
      @(negedge clk);
      if1.bd = (bc == 0);
      if2.bd = (bc == 0);
      bc = (bc + 1) % 4;
    end
  end

  // Sample index i holds the outputs just after posedge number i.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc < N) begin
        ser_h[0][cyc]  = if1.tx_serial;
        done_h[0][cyc] = if1.tx_done;
        busy_h[0][cyc] = if1.tx_busy;
        ser_h[1][cyc]  = if2.tx_serial;
        done_h[1][cyc] = if2.tx_done;
        busy_h[1][cyc] = if2.tx_busy;
      end
      cyc++;
    end
  end

  task automatic check(string tag, int got, int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rng(string tag, int got, int lo, int hi);
    checks++;
    assert (got >= lo && got <= hi)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  function automatic int find_val(int u, logic v, int from, int to);
    for (int i = from; i < to && i < N; i++)
      if (ser_h[u][i] === v) return i;
    return -1;
  endfunction

  function automatic int count_done(int u, int a, int b);
    int n = 0;
    for (int i = a; i < b && i < N; i++)
      if (done_h[u][i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int decode(int u, int f);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = ser_h[u][f + 96 + 64 * k];
    return int'(b);
  endfunction

  function automatic int last_rise(int u, int d);
    int r = d;
    while (r > 0 && ser_h[u][r-1] === 1'b1) r--;
    return r;
  endfunction

  task automatic strobe(int u, logic [7:0] b, output int acc);
    @(negedge clk);
    if (u == 0) begin if1.tx_start = 1'b1; if1.tx_byte = b; end
    else        begin if2.tx_start = 1'b1; if2.tx_byte = b; end
    acc = cyc;
    @(negedge clk);
    if (u == 0) if1.tx_start = 1'b0;
    else        if2.tx_start = 1'b0;
  endtask

  task automatic wait_done(int u, int limit, output int d);
    d = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if ((u == 0 ? if1.tx_done : if2.tx_done) === 1'b1) begin
        d = cyc - 1;
        break;
      end
    end
    check("done_seen", int'(d >= 0), 1);
  endtask

  // Checks one full frame whose start was accepted at sample acc and whose Done is at d.
  task automatic check_frame(int u, int acc, int d, logic [7:0] exp, int sb, output int f);
    f = find_val(u, 1'b0, acc, acc + 80);
    check("fall_after_accept", f - acc, 1);
    if (f < 0) f = acc + 1;
    check("busy_before", int'(busy_h[u][acc]), 0);
    check("busy_aligned", int'(busy_h[u][f]), 1);
    check("data_bits", decode(u, f), int'(exp));
    check("stop_level", int'(ser_h[u][f + 96 + 512]), 1);
    if (d >= 0) begin
      check_rng("frame_len", d - f, 573 + 64 * sb, 576 + 64 * sb);
      check("done_count", count_done(u, f, d + 2), 1);
      check("done_width", int'(done_h[u][d + 1]), 0);
      check("busy_after", int'(busy_h[u][d + 1]), 0);
    end
    $display("frame dut%0d byte=%02h decoded=%02h fall=%0d done=%0d", u, exp, decode(u, f), f, d);
  endtask

  initial begin
    int acc, acc2, d, d1, f, f2, r, z, a;

    rst = 1'b1;
    if1.tx_start = 1'b0; if1.tx_byte = 8'h00;
    if2.tx_start = 1'b0; if2.tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_serial", int'(if1.tx_serial), 1);
    check("rst_busy", int'(if1.tx_busy), 0);
    check("rst_done", int'(if1.tx_done), 0);
    check("rst_serial_sb2", int'(if2.tx_serial), 1);
    rst = 1'b0;

    // Idle with no start request.
    a = cyc;
    repeat (200) @(negedge clk);
    check("idle_no_fall", find_val(0, 1'b0, a, cyc), -1);
    check("idle_no_done", count_done(0, a, cyc), 0);
    check("idle_busy", int'(if1.tx_busy), 0);
    $display("idle 200 clocks from sample %0d", a);

    // 0xA5: data bits 1,0,1,0,0,1,0,1 LSB-first.
    strobe(0, 8'hA5, acc);
    wait_done(0, 900, d);
    check_frame(0, acc, d, 8'hA5, 1, f);
    r = find_val(0, 1'b1, f, f + 80);
    check_rng("start_len", r - f, 61, 64);
    z = find_val(0, 1'b0, r, r + 100);
    check("bit0_len", z - r, 64);
    if (d >= 0) check("stop_hold_a5", d - last_rise(0, d), 128);

    // 0x00 then 0xFF, second start in the cycle after Done.
    strobe(0, 8'h00, acc);
    wait_done(0, 900, d1);
    check_frame(0, acc, d1, 8'h00, 1, f);
    strobe(0, 8'hFF, acc2);
    wait_done(0, 900, d);
    check_frame(0, acc2, d, 8'hFF, 1, f2);
    if (d1 >= 0) check("b2b_gap", f2 - d1, 3);

    // Start request and byte change mid-frame are ignored.
    strobe(0, 8'h3C, acc);
    repeat (200) @(negedge clk);
    strobe(0, 8'h81, a);
    if1.tx_byte = 8'hFF;
    wait_done(0, 900, d);
    check_frame(0, acc, d, 8'h3C, 1, f);
    a = cyc;
    repeat (700) @(negedge clk);
    check("ignored_no_fall", find_val(0, 1'b0, a, cyc), -1);
    check("ignored_no_done", count_done(0, a, cyc), 0);

    // Reset during data bit 4 of 0x55, then a clean 0x0F frame.
    strobe(0, 8'h55, acc);
    while (cyc < acc + 1 + 352) @(negedge clk);
    check("pre_rst_busy", int'(if1.tx_busy), 1);
    check("pre_rst_bit3", int'(ser_h[0][acc + 1 + 96 + 64 * 3]), 0);
    rst = 1'b1;
    a = cyc;
    @(negedge clk);
    check("midrst_serial", int'(if1.tx_serial), 1);
    check("midrst_busy", int'(if1.tx_busy), 0);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    check("midrst_no_done", count_done(0, a, cyc), 0);
    check("midrst_line_high", find_val(0, 1'b0, a, cyc), -1);
    $display("reset mid-frame at sample %0d", a);
    strobe(0, 8'h0F, acc);
    wait_done(0, 900, d);
    check_frame(0, acc, d, 8'h0F, 1, f);

    // Two stop bits: 0xC3 ends with bits 1,1 then 128 clocks of stop.
    strobe(1, 8'hC3, acc);
    wait_done(1, 1000, d);
    check_frame(1, acc, d, 8'hC3, 2, f);
    if (d >= 0) check("stop_hold_sb2", d - last_rise(1, d), 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
